// File: rtl/layer_input_sequencer.sv
// Captures a fully valid vector from the producing layer and streams it one
// element per cycle, broadcast to every neuron of the consuming layer.
module layer_input_sequencer #(
    parameter int unsigned NN_IN  = 30,
    parameter int unsigned NN_OUT = 10,
    parameter int unsigned DW     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NN_IN-1:0]     in_valid,
    input  logic [NN_IN*DW-1:0]  in_data,
    input  logic                 clear_err,
    output logic [NN_OUT-1:0]    out_valid,
    output logic [NN_OUT*DW-1:0] out_data,
    output logic                 busy,
    output logic                 overrun,
    output logic                 vec_err,
    output logic [15:0]          vec_count
);

    localparam int unsigned IDX_W = (NN_IN > 1) ? $clog2(NN_IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN_IN - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    vec_buf_q [NN_IN];
    logic [DW-1:0]    vec_buf_d [NN_IN];
    logic [DW-1:0]    in_elem   [NN_IN];
    logic [DW-1:0]    out_elem_q, out_elem_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_d, overrun_d, vec_err_d;
    logic             capture_c, partial_c, cnt_inc_c;

    for (genvar g = 0; g < NN_IN; g++) begin : g_slice
        assign in_elem[g] = in_data[g*DW +: DW];
    end

    assign capture_c = &in_valid;
    assign partial_c = (|in_valid) && !capture_c;

    // out_elem_q always holds the element currently presented (index idx_q)
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vec_buf_d   = vec_buf_q;
        out_elem_d  = out_elem_q;
        out_valid_d = 1'b0;
        busy_d      = busy;
        overrun_d   = overrun & ~clear_err;
        vec_err_d   = vec_err & ~clear_err;
        cnt_inc_c   = 1'b0;

        if (partial_c) begin
            vec_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (capture_c) begin
                    vec_buf_d   = in_elem;
                    idx_d       = '0;
                    out_elem_d  = in_elem[0];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (idx_q != LAST_IDX) begin
                    idx_d       = idx_q + IDX_W'(1);
                    out_elem_d  = vec_buf_q[idx_q + IDX_W'(1)];
                    out_valid_d = 1'b1;
                    if (capture_c) begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    cnt_inc_c = 1'b1;
                    if (capture_c) begin
                        vec_buf_d   = in_elem;
                        idx_d       = '0;
                        out_elem_d  = in_elem[0];
                        out_valid_d = 1'b1;
                    end else begin
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            for (int k = 0; k < NN_IN; k++) begin
                vec_buf_q[k] <= '0;
            end
            out_elem_q  <= '0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            vec_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vec_buf_q   <= vec_buf_d;
            out_elem_q  <= out_elem_d;
            out_valid_q <= out_valid_d;
            busy        <= busy_d;
            overrun     <= overrun_d;
            vec_err     <= vec_err_d;
        end
    end

    // Completed-vector counter, wraps modulo 2^16
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count <= '0;
        end else if (cnt_inc_c) begin
            vec_count <= vec_count + 16'(1);
        end
    end

    assign out_valid = {NN_OUT{out_valid_q}};
    assign out_data  = {NN_OUT{out_elem_q}};

endmodule

// File: tb/tb_layer_input_sequencer.sv
// Directed bench for layer_input_sequencer with NN_IN=4, NN_OUT=3, DW=16.
module tb_layer_input_sequencer;

    localparam int unsigned NN_IN  = 4;
    localparam int unsigned NN_OUT = 3;
    localparam int unsigned DW     = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NN_IN-1:0]     in_valid;
    logic [NN_IN*DW-1:0]  in_data;
    logic                 clear_err;
    logic [NN_OUT-1:0]    out_valid;
    logic [NN_OUT*DW-1:0] out_data;
    logic                 busy;
    logic                 overrun;
    logic                 vec_err;
    logic [15:0]          vec_count;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_cnt;
    logic [15:0] va [4];
    logic [15:0] vb [4];

    layer_input_sequencer #(.NN_IN(NN_IN), .NN_OUT(NN_OUT), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_err(clear_err), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .overrun(overrun), .vec_err(vec_err), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NN_IN*DW-1:0] pack(input logic [15:0] e [4]);
        return {e[3], e[2], e[1], e[0]};
    endfunction

    function automatic logic [63:0] rep(input logic [15:0] e);
        return 64'({e, e, e});
    endfunction

    // Checks one streamed element presented in the current cycle
    task automatic chk_elem(input string tag, input logic [15:0] e);
        check({tag, "_valid"}, 64'(out_valid), 64'(3'b111));
        check({tag, "_data"}, 64'(out_data), rep(e));
        check({tag, "_busy"}, 64'(busy), 64'(1'b1));
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(3'b000));
        check({tag, "_busy"}, 64'(busy), 64'(1'b0));
        check({tag, "_count"}, 64'(vec_count), 64'(exp_cnt));
    endtask

    initial begin
        va[0] = 16'h0001; va[1] = 16'h0002; va[2] = 16'h0003; va[3] = 16'h0004;
        vb[0] = 16'h0010; vb[1] = 16'h0020; vb[2] = 16'h0030; vb[3] = 16'h0040;
        rst = 1'b1; in_valid = '0; in_data = '0; clear_err = 1'b0; exp_cnt = 16'd0;
        tick(); tick();
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_flags", 64'({overrun, vec_err}), 64'(0));
        check("rst_count", 64'(vec_count), 64'(0));
        rst = 1'b0;
        tick();

        // basic stream
        in_valid = 4'hF; in_data = pack(va);
        tick();
        in_valid = '0;
        for (int k = 0; k < 4; k++) begin
            chk_elem($sformatf("basic_e%0d", k), va[k]);
            tick();
        end
        exp_cnt = 16'd1;
        chk_idle("basic_end");
        check("basic_hold", 64'(out_data), rep(16'h0004));
        check("basic_flags", 64'({overrun, vec_err}), 64'(0));

        // back-to-back on the last element
        in_valid = 4'hF; in_data = pack(va);
        tick();
        in_valid = '0;
        for (int k = 0; k < 4; k++) begin
            chk_elem($sformatf("b2b_a%0d", k), va[k]);
            if (k == 3) begin
                in_valid = 4'hF; in_data = pack(vb);
            end
            tick();
            in_valid = '0;
        end
        for (int k = 0; k < 4; k++) begin
            chk_elem($sformatf("b2b_b%0d", k), vb[k]);
            tick();
        end
        exp_cnt = 16'd3;
        chk_idle("b2b_end");
        check("b2b_overrun", 64'(overrun), 64'(0));

        // overrun while the 2nd element is driven
        in_valid = 4'hF; in_data = pack(va);
        tick();
        in_valid = '0;
        for (int k = 0; k < 4; k++) begin
            chk_elem($sformatf("ovr_e%0d", k), va[k]);
            if (k == 1) begin
                in_valid = 4'hF; in_data = pack(vb);
            end
            tick();
            in_valid = '0;
            if (k == 1) check("ovr_flag", 64'(overrun), 64'(1));
        end
        exp_cnt = 16'd4;
        chk_idle("ovr_end");
        tick();
        check("ovr_nostream", 64'(out_valid), 64'(0));
        check("ovr_sticky", 64'(overrun), 64'(1));
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("ovr_clear", 64'(overrun), 64'(0));

        // partial vector in IDLE, then set-wins-over-clear
        in_valid = 4'b0101; in_data = pack(vb);
        tick();
        in_valid = '0;
        check("part_err", 64'(vec_err), 64'(1));
        chk_idle("part_idle");
        tick();
        check("part_nostream", 64'(out_valid), 64'(0));
        clear_err = 1'b1; in_valid = 4'b0101;
        tick();
        clear_err = 1'b0; in_valid = '0;
        check("part_setwins", 64'(vec_err), 64'(1));
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("part_clear", 64'(vec_err), 64'(0));

        // asynchronous reset during the 3rd element
        in_valid = 4'hF; in_data = pack(va);
        tick();
        in_valid = '0;
        tick(); tick();
        chk_elem("rstm_pre", va[2]);
        #2;
        rst = 1'b1;
        #1;
        check("rstm_valid", 64'(out_valid), 64'(0));
        check("rstm_busy", 64'(busy), 64'(0));
        check("rstm_count", 64'(vec_count), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 16'd0;
        tick();
        chk_idle("rstm_after");
        in_valid = 4'hF; in_data = pack(vb);
        tick();
        in_valid = '0;
        for (int k = 0; k < 4; k++) begin
            chk_elem($sformatf("rstm_e%0d", k), vb[k]);
            tick();
        end
        exp_cnt = 16'd1;
        chk_idle("rstm_end");

        // count wrap from 0xFFFF
        force dut.vec_count = 16'hFFFF;
        #1;
        release dut.vec_count;
        #1;
        check("wrap_preset", 64'(vec_count), 64'(16'hFFFF));
        in_valid = 4'hF; in_data = pack(va);
        tick();
        in_valid = '0;
        for (int k = 0; k < 4; k++) begin
            chk_elem($sformatf("wrap_e%0d", k), va[k]);
            tick();
        end
        exp_cnt = 16'h0000;
        chk_idle("wrap_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_input_sequencer.md
Name: layer_input_sequencer

Overview:
Sits between two neuron layers. Captures the parallel outputs of the previous layer when the whole vector is valid, then serialises it one element per cycle. Each element is broadcast with a common valid strobe to every neuron of the next layer. Tracks overruns, malformed vectors and a completed-vector count for debug and status readout.

Parameters:
NN_IN, 30, number of neurons in the producing layer (elements per vector)
NN_OUT, 10, number of neurons in the consuming layer (broadcast fan-out)
DW, 16, data width of one neuron output/input

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-high
in_valid  input  NN_IN  per-neuron output valid from producing layer
in_data  input  NN_IN*DW  producing layer outputs; element k at bits [k*DW+DW-1 : k*DW]
clear_err  input  1  synchronous pulse; clears sticky error flags
out_valid  output  NN_OUT  broadcast valid to consuming layer; all bits identical
out_data  output  NN_OUT*DW  broadcast data; every DW slice carries the same element
busy  output  1  high while a vector is being streamed
overrun  output  1  sticky; a complete vector arrived while busy and could not be accepted
vec_err  output  1  sticky; in_valid was non-zero but not all-ones
vec_count  output  16  number of fully streamed vectors; wraps 0xFFFF -> 0

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, capture buffer=0, out_valid=0, out_data=0, busy=0, overrun=0, vec_err=0, vec_count=0. Reset asserted mid-stream aborts the vector immediately. No further out_valid is issued and vec_count is not incremented.
- Capture condition: in_valid all-ones (&in_valid). All in_data slices are latched into an NN_IN x DW buffer on that edge.
- Partial vector: in_valid != 0 and != all-ones. Set vec_err and discard. State, idx and busy are unaffected.
- States:
  - IDLE: on capture, latch the buffer, set idx=0 and go to SEND. busy rises on the same edge.
  - SEND: each cycle drive out_valid=all-ones and out_data = buffer[idx] replicated NN_OUT times. These outputs are registered.
    - If idx < NN_IN-1: idx increments.
    - If idx == NN_IN-1: vec_count increments. Then:
      - If a capture occurs on this same cycle, re-latch the buffer, set idx=0 and stay in SEND (back-to-back, no bubble).
      - Otherwise return to IDLE.
- Latency: capture edge at cycle T gives the first out_valid at cycle T+1 and the last at T+NN_IN. out_valid is high for exactly NN_IN consecutive cycles per vector.
- busy:
  - High during cycles T+1..T+NN_IN.
  - Drops the cycle after the last element unless a back-to-back vector was accepted.
- Overrun: a capture condition while in SEND with idx != NN_IN-1 sets overrun. That vector is dropped and the current stream continues unchanged.
- Sticky flags hold until clear_err=1 or rst. If clear_err and a new error occur in the same cycle, the flag is set (the set wins).
- In IDLE, out_valid=0 and out_data holds its last value. Downstream qualifies data only by out_valid.
- There is no backpressure: the consuming neurons accept one input per cycle unconditionally.
- Arithmetic: idx is $clog2(NN_IN) bits (minimum 1). vec_count is modulo 2^16.

Test Plan:
All scenarios use NN_IN=4, NN_OUT=3, DW=16.
1. Basic stream:
   - Stimulus: pulse in_valid=4'b1111 for one cycle with in_data elements {0x0001, 0x0002, 0x0003, 0x0004} (element 0 = 0x0001).
   - Response: out_valid=3'b111 for 4 cycles, starting the cycle after capture. out_data slices all equal 0x0001, 0x0002, 0x0003, 0x0004 in that order. busy high for those 4 cycles. vec_count=1. No flags set.
2. Back-to-back:
   - Stimulus: second all-valid pulse {0x0010, 0x0020, 0x0030, 0x0040} on the cycle the 4th element (0x0004) is driven.
   - Response: 8 consecutive out_valid cycles with no gap. busy stays high. vec_count=2. overrun=0.
3. Overrun:
   - Stimulus: second all-valid pulse while the 2nd element is being driven.
   - Response: overrun=1. Stream still outputs the original 4 elements only. vec_count=1. clear_err pulse returns overrun to 0.
4. Partial vector:
   - Stimulus: in_valid=4'b0101 in IDLE.
   - Response: vec_err=1. No out_valid. busy=0. vec_count unchanged.
5. Reset mid-stream:
   - Stimulus: assert rst asynchronously (between clock edges) during the 3rd element.
   - Response: out_valid, busy and vec_count go to 0 immediately, without waiting for a clock edge. After release, a new vector streams correctly from element 0.
6. Count wrap:
   - Stimulus: stream 65536 vectors (or force vec_count=0xFFFF, then stream one).
   - Response: vec_count=0x0000.
